// File: rtl/weight_load_sched_if.sv
// Weight beat stream plus buffer-side write/read signals of the weight load scheduler.
interface weight_load_sched_if #(
    parameter int ADDR_BIT = 9
);
    logic [31:0]         s_data;
    logic                s_valid;
    logic                s_ready;
    logic                buf_clear;
    logic                buf_wr_en;
    logic [31:0]         buf_in;
    logic [ADDR_BIT-1:0] buf_read_addr;
    logic                grp_valid;
    logic                grp_next;

    modport master (
        input  s_data, s_valid, grp_next,
        output s_ready, buf_clear, buf_wr_en, buf_in, buf_read_addr, grp_valid
    );
    modport slave (
        output s_data, s_valid, grp_next,
        input  s_ready, buf_clear, buf_wr_en, buf_in, buf_read_addr, grp_valid
    );
endinterface

// File: rtl/weight_load_sched.sv
// Clears and fills the 8-lane int4 weight buffer, then walks its read address one group
// at a time under the conv engine's grp_next handshake.
module weight_load_sched #(
    parameter int ADDR_BIT        = 9,
    parameter int MAX_GROUPS      = 512,
    parameter int BEATS_PER_GROUP = 72,
    parameter int READ_LAT        = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_BIT-1:0] num_groups,
    output logic                busy,
    output logic                done,
    output logic                err,
    weight_load_sched_if.master bus
);
    localparam int BW  = (BEATS_PER_GROUP > 1) ? $clog2(BEATS_PER_GROUP) : 1;
    localparam int SW  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int AW1 = ADDR_BIT + 1;
    localparam logic [BW-1:0]  LAST_BEAT   = BW'(BEATS_PER_GROUP - 1);
    localparam logic [SW-1:0]  LAST_SETTLE = SW'(READ_LAT - 1);
    localparam logic [AW1-1:0] MAX_G       = AW1'(MAX_GROUPS);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_SERVE, S_DONE} state_t;

    state_t              state;
    logic [BW-1:0]       beat_cnt;
    logic [ADDR_BIT-1:0] grp_cnt;
    logic [ADDR_BIT-1:0] last_grp;
    logic [ADDR_BIT-1:0] rd_addr;
    logic [SW-1:0]       settle_cnt;
    logic                clear_q;
    logic                grp_valid_q;
    logic                err_q;
    logic                vld_p1;
    logic [31:0]         data_p1;
    logic                accept;
    logic                start_ok;

    assign start_ok = (num_groups != '0) && (AW1'(num_groups) <= MAX_G);
    assign accept   = (state == S_LOAD) && bus.s_valid && !abort;

    // abort must silence the buffer-facing strobes in the very cycle it is seen
    assign bus.s_ready       = (state == S_LOAD) && !abort;
    assign bus.buf_clear     = clear_q && !abort;
    assign bus.buf_wr_en     = vld_p1 && !abort;
    assign bus.grp_valid     = grp_valid_q && !abort;
    assign bus.buf_in        = data_p1;
    assign bus.buf_read_addr = rd_addr;
    assign busy              = (state != S_IDLE);
    assign done              = (state == S_DONE);
    assign err               = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            beat_cnt    <= '0;
            grp_cnt     <= '0;
            last_grp    <= '0;
            rd_addr     <= '0;
            settle_cnt  <= '0;
            clear_q     <= 1'b0;
            grp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            vld_p1      <= 1'b0;
            data_p1     <= '0;
        end else begin
            clear_q <= 1'b0;
            err_q   <= 1'b0;
            // stage p1: accepted beat is presented to the buffer one cycle later
            vld_p1  <= accept;
            if (accept)
                data_p1 <= bus.s_data;

            if (abort) begin
                state       <= S_IDLE;
                grp_valid_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (start_ok) begin
                                last_grp <= num_groups - 1'b1;
                                rd_addr  <= '0;
                                clear_q  <= 1'b1;
                                state    <= S_CLEAR;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    S_CLEAR: begin
                        beat_cnt <= '0;
                        grp_cnt  <= '0;
                        state    <= S_LOAD;
                    end
                    S_LOAD: begin
                        if (bus.s_valid) begin
                            if (beat_cnt == LAST_BEAT) begin
                                beat_cnt <= '0;
                                if (grp_cnt == last_grp) begin
                                    rd_addr     <= '0;
                                    settle_cnt  <= '0;
                                    grp_valid_q <= 1'b0;
                                    state       <= S_SERVE;
                                end else begin
                                    grp_cnt <= grp_cnt + 1'b1;
                                end
                            end else begin
                                beat_cnt <= beat_cnt + 1'b1;
                            end
                        end
                    end
                    S_SERVE: begin
                        if (grp_valid_q) begin
                            if (bus.grp_next) begin
                                grp_valid_q <= 1'b0;
                                settle_cnt  <= '0;
                                if (rd_addr == last_grp)
                                    state <= S_DONE;
                                else
                                    rd_addr <= rd_addr + 1'b1;
                            end
                        end else if (settle_cnt == LAST_SETTLE) begin
                            grp_valid_q <= 1'b1;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_weight_load_sched.sv
// Randomized bench for weight_load_sched: a transaction-level model predicts every output
// each cycle, and directed literal checks pin beat counts, settle delay and error handling.
module tb_weight_load_sched;
    localparam int READ_LAT = 2;
    localparam int BPG      = 72;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [8:0] ngrp = '0;
    logic       busy, done, err;

    logic       start2 = 1'b0;
    logic       abort2 = 1'b0;
    logic [9:0] ngrp2 = '0;
    logic       busy2, done2, err2;

    weight_load_sched_if #(.ADDR_BIT(9))  bus ();
    weight_load_sched_if #(.ADDR_BIT(10)) bus2 ();

    weight_load_sched #(.ADDR_BIT(9), .MAX_GROUPS(512), .BEATS_PER_GROUP(BPG), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_groups(ngrp),
        .busy(busy), .done(done), .err(err), .bus(bus)
    );

    weight_load_sched #(.ADDR_BIT(10), .MAX_GROUPS(512), .BEATS_PER_GROUP(BPG), .READ_LAT(READ_LAT)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .num_groups(ngrp2),
        .busy(busy2), .done(done2), .err(err2), .bus(bus2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a load is "ng*72 beats to accept", then "ng groups to hand out",
    // with each group visible READ_LAT cycles after its address appears.
    bit          m_active = 0, m_clearcyc = 0, m_serving = 0, m_done = 0, m_err = 0, m_wr = 0;
    int          m_beats = 0, m_total = 0, m_ng = 0, m_addr = 0, m_age = 0;
    logic [31:0] m_data = '0;

    function automatic bit m_loading();
        return m_active && !m_clearcyc && !m_serving && !m_done && (m_beats < m_total);
    endfunction

    initial begin
        bit acc;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_active = 0; m_clearcyc = 0; m_serving = 0; m_done = 0; m_err = 0; m_wr = 0;
                m_beats = 0; m_total = 0; m_addr = 0; m_age = 0; m_data = '0;
            end else begin
                acc   = m_loading() && bus.s_valid && !abort;
                m_wr  = acc;
                if (acc) m_data = bus.s_data;
                m_err = 0;
                if (abort) begin
                    m_active = 0; m_clearcyc = 0; m_serving = 0; m_done = 0;
                end else if (!m_active) begin
                    if (start) begin
                        if (ngrp >= 1 && int'(ngrp) <= 512) begin
                            m_active = 1; m_clearcyc = 1; m_ng = int'(ngrp);
                            m_total = m_ng * BPG; m_beats = 0; m_addr = 0;
                        end else begin
                            m_err = 1;
                        end
                    end
                end else if (m_done) begin
                    m_done = 0; m_active = 0;
                end else if (m_clearcyc) begin
                    m_clearcyc = 0;
                end else if (m_beats < m_total) begin
                    if (acc) begin
                        m_beats++;
                        if (m_beats == m_total) begin m_serving = 1; m_age = 0; end
                    end
                end else if (m_serving) begin
                    if (m_age >= READ_LAT && bus.grp_next) begin
                        if (m_addr == m_ng - 1) begin m_serving = 0; m_done = 1; end
                        else begin m_addr++; m_age = 0; end
                    end else if (m_age < READ_LAT) begin
                        m_age++;
                    end
                end
            end
        end
    end

    int wr_count = 0, clear_count = 0, done_count = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("busy", busy, m_active);
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("s_ready", bus.s_ready, m_loading() && !abort);
            chk("buf_clear", bus.buf_clear, m_clearcyc && !abort);
            chk("buf_wr_en", bus.buf_wr_en, m_wr && !abort);
            chk("buf_in", bus.buf_in, m_data);
            chk("buf_read_addr", bus.buf_read_addr, m_addr);
            chk("grp_valid", bus.grp_valid, m_serving && (m_age >= READ_LAT) && !abort);
        end else begin
            chk("rst_outputs", {busy, done, err, bus.s_ready, bus.buf_clear, bus.buf_wr_en, bus.grp_valid}, 0);
            chk("rst_buf_in", bus.buf_in, 0);
            chk("rst_addr", bus.buf_read_addr, 0);
        end
        if (bus.buf_wr_en) wr_count <= wr_count + 1;
        if (bus.buf_clear) clear_count <= clear_count + 1;
        if (done) done_count <= done_count + 1;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input int ng);
        ngrp  = 9'(ng);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: s_valid held, 1/2/3 lane pattern; mode 1: s_valid every other cycle; mode 2: random
    task automatic stream(input int total, input int mode, input int abort_at, input int start_at);
        int acc = 0;
        int guard = 0;
        bit started = 0;
        logic [3:0] nib;
        while (acc < total && guard < 20000) begin
            nib = 4'(acc % 3 + 1);
            bus.s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
            bus.s_data  = (mode == 0) ? {8{nib}} : $urandom;
            abort = (abort_at >= 0 && acc == abort_at && bus.s_valid);
            start = (start_at >= 0 && acc == start_at && !started);
            if (start) begin started = 1; ngrp = 9'd5; end
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) acc++;
            tick();
            start = 1'b0;
            guard++;
            if (abort) break;
        end
        abort = 1'b0;
        bus.s_valid = 1'b0;
        if (guard >= 20000) chk("stream_timeout", acc, total);
    endtask

    task automatic serve(input int ng, input int nnext, input bit early);
        for (int g = 0; g < ng && g <= nnext; g++) begin
            int lows = 0;
            while (lows < 50) begin
                @(negedge clk);
                if (bus.grp_valid) break;
                if (early && lows == 0) bus.grp_next = 1'b1;
                lows++;
                tick();
                bus.grp_next = 1'b0;
            end
            chk("settle_cycles", lows, READ_LAT);
            chk("group_addr", bus.buf_read_addr, g);
            if (g == nnext) return;
            bus.grp_next = 1'b1;
            tick();
            bus.grp_next = 1'b0;
        end
        @(negedge clk);
        chk("done_pulse", {done, busy}, 2'b11);
        tick();
        @(negedge clk);
        chk("done_after", {done, busy}, 2'b00);
    endtask

    initial begin
        int w0, c0, d0;
        bus.s_valid = 0; bus.s_data = '0; bus.grp_next = 0;
        bus2.s_valid = 0; bus2.s_data = '0; bus2.grp_next = 0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();

        // single group, steady stream
        w0 = wr_count; c0 = clear_count; d0 = done_count;
        do_start(1);
        stream(72, 0, -1, -1);
        serve(1, 1, 0);
        chk("t1_writes", wr_count - w0, 72);
        chk("t1_clears", clear_count - c0, 1);
        chk("t1_dones", done_count - d0, 1);
        chk("t1_last_data", bus.buf_in, 32'h33333333);

        // three groups, gapped stream, stray start during LOAD, early grp_next
        w0 = wr_count; c0 = clear_count;
        do_start(3);
        stream(216, 1, -1, 10);
        serve(3, 3, 1);
        chk("t2_writes", wr_count - w0, 216);
        chk("t2_clears", clear_count - c0, 1);
        chk("t2_final_addr", bus.buf_read_addr, 2);

        // rejected starts
        c0 = clear_count;
        do_start(0);
        @(negedge clk);
        chk("ng0_err", {err, busy, bus.buf_clear}, 3'b100);
        tick();
        @(negedge clk);
        chk("ng0_err_gone", {err, busy}, 2'b00);
        chk("ng0_no_clear", clear_count - c0, 0);
        ngrp2 = 10'd513; start2 = 1'b1; tick(); start2 = 1'b0;
        @(negedge clk);
        chk("ng513_err", {err2, busy2, bus2.buf_clear, done2}, 4'b1000);
        ngrp2 = 10'd512; start2 = 1'b1; tick(); start2 = 1'b0;
        @(negedge clk);
        chk("ng512_ok", {err2, busy2, bus2.buf_clear}, 3'b011);
        abort2 = 1'b1; tick(); abort2 = 1'b0;
        @(negedge clk);
        chk("ng512_abort", busy2, 0);

        // abort on beat 40; the pending write of beat 39 is also masked in that cycle
        w0 = wr_count; d0 = done_count;
        do_start(2);
        stream(144, 0, 40, -1);
        @(negedge clk);
        chk("abort_idle", {busy, bus.s_ready, done}, 3'b000);
        chk("abort_writes", wr_count - w0, 39);
        chk("abort_no_done", done_count - d0, 0);
        w0 = wr_count; c0 = clear_count;
        do_start(1);
        stream(72, 2, -1, -1);
        serve(1, 1, 1);
        chk("reload_writes", wr_count - w0, 72);
        chk("reload_clears", clear_count - c0, 1);

        // asynchronous reset while serving group 1
        do_start(3);
        stream(216, 2, -1, -1);
        serve(3, 1, 0);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_ctl", {busy, done, err, bus.s_ready, bus.buf_clear, bus.buf_wr_en, bus.grp_valid}, 0);
        chk("async_rst_addr", bus.buf_read_addr, 0);
        chk("async_rst_data", bus.buf_in, 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("post_rst_idle", {busy, bus.s_ready}, 2'b00);
        w0 = wr_count;
        do_start(1);
        stream(72, 1, -1, -1);
        serve(1, 1, 0);
        chk("post_rst_writes", wr_count - w0, 72);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/weight_load_sched.md
Name: weight_load_sched

Overview:
- Sequences the 8-lane int4 weight buffer that feeds the 8x8 grid of 3x3 conv windows.
- Phase 1: accepts a stream of 32-bit weight beats (8 lanes x 4 bit), clears the buffer, then writes the beats in order.
- Phase 2: steps the buffer read address one weight group at a time, under a handshake from the conv engine.
- Sits between the weight DMA/UART front end and buffer_weight_1x8x8.

Parameters:
ADDR_BIT, 9, width of buffer read address and group counters
MAX_GROUPS, 512, largest legal num_groups
BEATS_PER_GROUP, 72, write beats per group (9 taps x 8 input channels)
READ_LAT, 2, cycles from read-address change until buffer window outputs are valid

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  single-cycle pulse; begins a load in IDLE, ignored elsewhere
abort  in  1  synchronous; forces return to IDLE from any state
num_groups  in  ADDR_BIT  groups to load; sampled on accepted start
s_data  in  32  weight beat; lane k = s_data[4k+3:4k]
s_valid  in  1  beat valid
s_ready  out  1  beat accepted when s_valid && s_ready
buf_clear  out  1  buffer clear strobe
buf_wr_en  out  1  buffer write enable (drives bram_en_write)
buf_in  out  32  lane data to buffer in_0..in_7 (lane k at [4k+3:4k])
buf_read_addr  out  ADDR_BIT  buffer read address (group index)
grp_valid  out  1  buffer window outputs for buf_read_addr are valid
grp_next  in  1  consumer pulse: finished with current group
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when last group is released
err  out  1  one-cycle pulse: start rejected

Behaviour:
- Reset (rst=0, async): state IDLE.
- All outputs 0 during reset; buf_read_addr=0; internal counters 0.
- States: IDLE, CLEAR, LOAD, SERVE, DONE.
- IDLE:
  - start with 1 <= num_groups <= MAX_GROUPS: latch num_groups, go to CLEAR.
  - start otherwise: err=1 for one cycle, stay in IDLE.
- CLEAR:
  - buf_clear=1 for exactly one cycle, s_ready=0.
  - Then go to LOAD; beat_cnt=0, grp_cnt=0.
- LOAD:
  - s_ready=1 combinationally, except on the cycle the final beat is accepted (last beat of last group), where it is still 1.
  - Each accepted beat, registered (1-cycle latency): next cycle buf_wr_en=1 and buf_in=s_data.
  - Otherwise buf_wr_en=0 and buf_in holds its value.
  - beat_cnt counts 0..BEATS_PER_GROUP-1, then wraps to 0 and grp_cnt increments.
  - s_valid gaps stall the counters with no write.
  - After the final beat is accepted, go to SERVE. The last buf_wr_en pulse occurs on the first SERVE cycle; s_ready=0 from then on.
- SERVE:
  - buf_read_addr starts at 0.
  - After every address change (including entry), grp_valid=0 for READ_LAT cycles, then 1.
  - grp_next while grp_valid=1:
    - Not the last group: buf_read_addr increments and the settle window restarts.
    - Last group: go to DONE.
  - grp_next while grp_valid=0 is ignored.
- DONE: done=1 for one cycle, busy=0 next cycle, go to IDLE. buf_read_addr holds its last value until the next start is accepted, which resets it to 0.
- abort:
  - Any state goes to IDLE next cycle.
  - s_ready, buf_wr_en, grp_valid and buf_clear drop to 0 at that cycle.
  - No done pulse.
  - abort has priority over start, grp_next and beat acceptance in the same cycle.
- start outside IDLE: ignored, no err.
- Reset mid-LOAD or mid-SERVE: immediate return to reset values. Partially written buffer contents are not guaranteed; the next load's CLEAR handles them.
- Counters are unsigned. grp_cnt compare uses num_groups-1 and cannot overflow, because num_groups <= MAX_GROUPS <= 2^ADDR_BIT.

Test Plan:
- Reset then start, num_groups=1; stream 72 beats of 0x11111111/0x22222222/0x33333333 repeating, s_valid held high -> buf_clear one cycle, then 72 buf_wr_en pulses each one cycle after acceptance with matching buf_in; grp_valid rises 2 cycles after SERVE entry; grp_next -> done pulse, busy=0.
- num_groups=3 with s_valid toggling every other cycle -> exactly 216 writes with no gaps mis-counted; buf_read_addr steps 0,1,2 on successive grp_next; grp_valid low 2 cycles after each step; done after the third grp_next.
- start with num_groups=0, and separately with num_groups=513 (ADDR_BIT=10 build) -> err pulse, state stays IDLE, busy=0, no buf_clear.
- grp_next asserted during the settle window, and start pulsed during LOAD -> both ignored; buf_read_addr and counters unchanged.
- abort on beat 40 of LOAD, with s_valid=1 in the same cycle -> beat not written, busy=0 next cycle, no done; a new start reloads from beat 0 with a fresh buf_clear.
- rst driven low asynchronously mid-SERVE at buf_read_addr=1 -> all outputs 0 immediately, without waiting for a clock edge; after release, state is IDLE.
